// File: rtl/phase_sequencer_pkg.sv
// traffic_pkg: shared interval type, width helper and lamp vector type for the phase sequencer
package traffic_pkg;
  typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} interval_t;
  typedef logic [3:0] lamp_t;
  function automatic int tick_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: sensor inputs and lamp/status outputs of the phase sequencer
// master drives actuated/car_det/ped_btn; slave drives lamps, countdown, phase_idx, sec_tick
interface phase_sequencer_if import traffic_pkg::*; #(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W = 7
);
  localparam int PW = tick_w(NUM_PHASES);
  logic actuated;
  logic [NUM_PHASES-1:0] car_det, ped_btn, green, yellow, red, walk, hand;
  logic [TIMER_W-1:0] countdown;
  logic [PW-1:0] phase_idx;
  logic sec_tick;
  modport master(
    output actuated, car_det, ped_btn,
    input green, yellow, red, walk, hand, countdown, phase_idx, sec_tick
  );
  modport slave(
    input actuated, car_det, ped_btn,
    output green, yellow, red, walk, hand, countdown, phase_idx, sec_tick
  );
endinterface

// File: rtl/phase_sequencer_prescaler.sv
// sec_prescaler: divides clk by CLK_HZ into a one-cycle seconds tick
// clk, rst_n (async active-low) in; o_sec_tick out, high on the cycle the counter wraps
module sec_prescaler import traffic_pkg::*; #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_sec_tick
);
  localparam int W = tick_w(CLK_HZ);
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
  logic [W-1:0] r_cnt;
  assign o_sec_tick = r_cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= o_sec_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: N-phase signal controller with clearance intervals, demand latching, skip and rest-in-green
// clk, rst_n (async active-low); bus (slave): actuated/car_det/ped_btn in; lamps, walk/hand, countdown, phase_idx, sec_tick out
module phase_sequencer import traffic_pkg::*; #(
  parameter int NUM_PHASES = 4,
  parameter int CLK_HZ = 1000,
  parameter int TIMER_W = 7,
  parameter int LONG_GREEN = 120,
  parameter int SHORT_GREEN = 60,
  parameter logic [NUM_PHASES-1:0] SHORT_MASK = 4'b1010,
  parameter logic [NUM_PHASES-1:0] WALK_MASK = 4'b0101,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int DEMAND_CUT = 30,
  parameter int PED_CLEAR = 10
) (
  input logic clk,
  input logic rst_n,
  phase_sequencer_if.slave bus
);
  localparam int PW = tick_w(NUM_PHASES);
  interval_t r_state, w_state;
  logic [PW-1:0] r_phase, w_phase, r_idx;
  logic [TIMER_W-1:0] r_rem, w_rem, r_cd, w_cd;
  logic [NUM_PHASES-1:0] r_demand, w_demand, w_act, w_other, w_enter;
  logic [NUM_PHASES-1:0] w_green, w_yellow, w_walk, r_green, r_yellow, r_red, r_walk;
  logic w_tick, w_rest, r_tick;
  // first demanded phase strictly after cur (wrapping to cur itself last); plain successor otherwise
  function automatic logic [PW-1:0] next_phase(
    input logic [PW-1:0] cur,
    input logic [NUM_PHASES-1:0] dem,
    input logic act
  );
    logic [PW-1:0] sel, j;
    sel = PW'((int'(cur) + 1) % NUM_PHASES);
    for (int k = NUM_PHASES; k >= 1; k--) begin
      j = PW'((int'(cur) + k) % NUM_PHASES);
      if (act && dem[j]) sel = j;
    end
    return sel;
  endfunction
  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (.clk(clk), .rst_n(rst_n), .o_sec_tick(w_tick));
  always_comb begin
    w_act = NUM_PHASES'(1) << r_phase;
    w_other = r_demand & ~w_act;
    w_rest = bus.actuated && !(|w_other);
    w_state = r_state;
    w_phase = r_phase;
    w_rem = r_rem;
    if (r_state == GREEN && |w_other && r_rem > TIMER_W'(DEMAND_CUT)) w_rem = TIMER_W'(DEMAND_CUT);
    else if (w_tick && r_rem != '0) w_rem = r_rem - 1'b1;
    else if (w_tick && r_state == GREEN) begin
      w_state = w_rest ? GREEN : YELLOW;
      w_rem = w_rest ? r_rem : TIMER_W'(YELLOW_TIME);
    end else if (w_tick && r_state == YELLOW) begin
      w_state = ALL_RED;
      w_rem = TIMER_W'(ALLRED_TIME);
    end else if (w_tick) begin
      w_state = GREEN;
      w_phase = next_phase(r_phase, r_demand, bus.actuated);
      w_rem = SHORT_MASK[w_phase] ? TIMER_W'(SHORT_GREEN) : TIMER_W'(LONG_GREEN);
    end
    // entering green clears that phase's demand even if it is being requested this very cycle
    w_enter = (r_state == ALL_RED && w_state == GREEN) ? NUM_PHASES'(1) << w_phase : '0;
    w_demand = (r_demand | ((bus.car_det | (bus.ped_btn & WALK_MASK)) & ~(r_state == GREEN ? w_act : '0))) & ~w_enter;
    w_green = r_state == GREEN ? w_act : '0;
    w_yellow = r_state == YELLOW ? w_act : '0;
    w_walk = (r_state == GREEN && r_rem > TIMER_W'(PED_CLEAR)) ? (w_act & WALK_MASK) : '0;
    w_cd = (r_state == GREEN && |(w_act & WALK_MASK)) ? r_rem : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ALL_RED;
      r_phase <= PW'(NUM_PHASES - 1);
      r_rem <= TIMER_W'(ALLRED_TIME);
      r_demand <= '0;
      r_green <= '0;
      r_yellow <= '0;
      r_red <= '1;
      r_walk <= '0;
      r_cd <= '0;
      r_idx <= PW'(NUM_PHASES - 1);
      r_tick <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_rem <= w_rem;
      r_demand <= w_demand;
      r_green <= w_green;
      r_yellow <= w_yellow;
      r_red <= ~(w_green | w_yellow);
      r_walk <= w_walk;
      r_cd <= w_cd;
      r_idx <= r_phase;
      r_tick <= w_tick;
    end
  assign bus.green = r_green;
  assign bus.yellow = r_yellow;
  assign bus.red = r_red;
  assign bus.walk = r_walk;
  assign bus.hand = ~r_walk;
  assign bus.countdown = r_cd;
  assign bus.phase_idx = r_idx;
  assign bus.sec_tick = r_tick;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized and directed checks of phase_sequencer against a seconds-level reference model
module tb_phase_sequencer;
  import traffic_pkg::*;
  localparam int N = 4;
  localparam int HZ = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  phase_sequencer_if #(.NUM_PHASES(N), .TIMER_W(7)) bus();
  phase_sequencer #(.NUM_PHASES(N), .CLK_HZ(HZ), .TIMER_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  bit [3:0] short_m = 4'b1010;
  bit [3:0] walk_m = 4'b0101;
  int m_mode, m_phase, m_rem, m_pre;
  bit [3:0] m_dem;
  lamp_t e_green, e_yellow, e_red, e_walk, e_hand;
  logic [6:0] e_cd;
  logic [1:0] e_idx;
  logic e_tick;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input int cur, input bit [3:0] dem, input bit act);
    if (act) for (int k = 1; k <= N; k++) if (dem[(cur + k) % N]) return (cur + k) % N;
    return (cur + 1) % N;
  endfunction
  task automatic model_reset();
    m_mode = 2; m_phase = N - 1; m_rem = 2; m_pre = 0; m_dem = '0;
    e_green = '0; e_yellow = '0; e_red = '1; e_walk = '0; e_hand = '1;
    e_cd = '0; e_idx = 2'(N - 1); e_tick = 1'b0;
  endtask
  // one clock of the reference: outputs show the interval held before this edge, then the interval advances
  task automatic model_step(input bit act, input bit [3:0] cd, input bit [3:0] pb);
    bit [3:0] set, nd, me;
    bit other, tick;
    int om, op;
    me = 4'(1 << m_phase);
    e_green = m_mode == 0 ? me : 4'b0;
    e_yellow = m_mode == 1 ? me : 4'b0;
    e_red = ~(e_green | e_yellow);
    e_walk = (m_mode == 0 && walk_m[m_phase] && m_rem > 10) ? me : 4'b0;
    e_hand = ~e_walk;
    e_cd = (m_mode == 0 && walk_m[m_phase]) ? 7'(m_rem) : 7'd0;
    e_idx = 2'(m_phase);
    e_tick = m_pre == HZ - 1;
    tick = e_tick;
    m_pre = tick ? 0 : m_pre + 1;
    set = cd | (pb & walk_m);
    other = |(m_dem & ~me);
    om = m_mode;
    op = m_phase;
    if (m_mode == 0 && other && m_rem > 30) m_rem = 30;
    else if (tick && m_rem > 0) m_rem = m_rem - 1;
    else if (tick) begin
      if (m_mode == 0) begin
        if (!(act && !other)) begin m_mode = 1; m_rem = 4; end
      end else if (m_mode == 1) begin
        m_mode = 2; m_rem = 2;
      end else begin
        m_mode = 0; m_phase = pick(op, m_dem, act); m_rem = short_m[m_phase] ? 60 : 120;
      end
    end
    for (int q = 0; q < N; q++) nd[q] = m_dem[q] | (set[q] && !(om == 0 && q == op));
    if (om == 2 && m_mode == 0) nd[m_phase] = 1'b0;
    m_dem = nd;
  endtask
  task automatic compare_all();
    bit ok;
    chk("green", 32'(bus.green), 32'(e_green));
    chk("yellow", 32'(bus.yellow), 32'(e_yellow));
    chk("red", 32'(bus.red), 32'(e_red));
    chk("walk", 32'(bus.walk), 32'(e_walk));
    chk("hand", 32'(bus.hand), 32'(e_hand));
    chk("countdown", 32'(bus.countdown), 32'(e_cd));
    chk("phase_idx", 32'(bus.phase_idx), 32'(e_idx));
    chk("sec_tick", 32'(bus.sec_tick), 32'(e_tick));
    ok = 1'b1;
    for (int p = 0; p < N; p++) if (int'(bus.green[p]) + int'(bus.yellow[p]) + int'(bus.red[p]) != 1) ok = 1'b0;
    chk("lamp_onehot", 32'(ok), 32'd1);
  endtask
  task automatic cycle();
    bit a;
    bit [3:0] c, p;
    @(posedge clk);
    a = bus.actuated;
    c = bus.car_det;
    p = bus.ped_btn;
    if (rst_n) model_step(a, c, p);
    else model_reset();
    #1 compare_all();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic hard_reset(input bit act);
    rst_n = 1'b0;
    model_reset();
    bus.actuated = act;
    bus.car_det = '0;
    bus.ped_btn = '0;
    run(2);
    rst_n = 1'b1;
  endtask
  task automatic wait_green_ne(input int p, input int lim);
    int n = 0;
    while (!(bus.green != 0 && int'(bus.phase_idx) != p) && n < lim) begin cycle(); n++; end
    chk("wait_green", 32'(bus.green != 0 && int'(bus.phase_idx) != p), 32'd1);
  endtask
  task automatic wait_cd(input int v, input int lim);
    int n = 0;
    while (!(bus.green != 0 && int'(bus.countdown) == v) && n < lim) begin cycle(); n++; end
    chk("wait_countdown", 32'(bus.green != 0 && int'(bus.countdown) == v), 32'd1);
  endtask
  task automatic pulse_car(input int p);
    bus.car_det = 4'(1 << p);
    cycle();
    bus.car_det = '0;
  endtask
  initial begin
    int n;
    model_reset();
    bus.actuated = 1'b0;
    bus.car_det = '0;
    bus.ped_btn = '0;
    run(2);
    chk("rst_red", 32'(bus.red), 32'hF);
    chk("rst_hand", 32'(bus.hand), 32'hF);
    chk("rst_green", 32'(bus.green | bus.yellow | bus.walk), 32'd0);
    chk("rst_countdown", 32'(bus.countdown), 32'd0);
    chk("rst_idx", 32'(bus.phase_idx), 32'd3);
    rst_n = 1'b1;
    // fixed-time recall visits every phase in order
    wait_green_ne(-1, 200);
    chk("recall_first", 32'(bus.phase_idx), 32'd0);
    chk("recall_first_cd", 32'(bus.countdown), 32'd120);
    for (int p = 0; p < N; p++) begin
      wait_green_ne(p, 2000);
      chk("recall_order", 32'(bus.phase_idx), 32'((p + 1) % N));
    end
    // conflicting demand truncates phase-0 green and phase 1 is skipped
    hard_reset(1'b1);
    wait_cd(100, 1000);
    pulse_car(2);
    run(2);
    chk("cut_to_30", 32'(bus.countdown), 32'd30);
    wait_green_ne(0, 1000);
    chk("skip_to_2", 32'(bus.phase_idx), 32'd2);
    // rest in green; own-phase and non-walk buttons do not create demand
    hard_reset(1'b1);
    wait_cd(0, 3000);
    bus.ped_btn = 4'b0011;
    run(5);
    bus.ped_btn = '0;
    run(40);
    chk("rest_green", 32'(bus.green), 32'b0001);
    chk("rest_walk", 32'(bus.walk), 32'd0);
    pulse_car(3);
    wait_green_ne(0, 200);
    chk("rest_to_3", 32'(bus.phase_idx), 32'd3);
    // pedestrian call on phase 2: walk until clearance, then hand
    bus.ped_btn = 4'b0100;
    cycle();
    bus.ped_btn = '0;
    wait_green_ne(3, 1500);
    chk("ped_to_2", 32'(bus.phase_idx), 32'd2);
    wait_cd(11, 1300);
    chk("walk_11", 32'(bus.walk), 32'b0100);
    wait_cd(10, 100);
    chk("walk_10", 32'(bus.walk), 32'd0);
    chk("hand_10", 32'(bus.hand), 32'hF);
    // demand arriving on the edge its phase enters green is discarded
    hard_reset(1'b0);
    n = 0;
    while (!(m_mode == 2 && m_rem == 0 && m_pre == HZ - 1 && m_phase == 0) && n < 3000) begin cycle(); n++; end
    chk("entry_found", 32'(n < 3000), 32'd1);
    bus.car_det = 4'b0010;
    cycle();
    bus.car_det = '0;
    bus.actuated = 1'b1;
    cycle();
    chk("entry_green1", 32'(bus.green), 32'b0010);
    run(700);
    chk("entry_rest1", 32'(bus.green), 32'b0010);
    pulse_car(3);
    wait_green_ne(1, 200);
    chk("entry_to_3", 32'(bus.phase_idx), 32'd3);
    run(800);
    chk("no_stale_demand", 32'(bus.green), 32'b1000);
    // asynchronous reset in the middle of yellow
    pulse_car(0);
    n = 0;
    while (bus.yellow == 0 && n < 100) begin cycle(); n++; end
    chk("saw_yellow", 32'(bus.yellow != 0), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_red", 32'(bus.red), 32'hF);
    chk("arst_hand", 32'(bus.hand), 32'hF);
    chk("arst_gy", 32'(bus.green | bus.yellow | bus.walk), 32'd0);
    chk("arst_countdown", 32'(bus.countdown), 32'd0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    wait_green_ne(-1, 200);
    chk("arst_first0", 32'(bus.phase_idx), 32'd0);
    // randomized sensor traffic with occasional mode flips and resets
    for (int i = 0; i < 5000; i++) begin
      bus.car_det = $urandom_range(0, 99) < 3 ? 4'($urandom) : 4'b0;
      bus.ped_btn = $urandom_range(0, 99) < 2 ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 499) == 0) bus.actuated = ~bus.actuated;
      if ($urandom_range(0, 1999) == 0) hard_reset(bus.actuated);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
